free_list: RTL and testbench

Hardware physical-register free list for the 3-way rename/dispatch stage. It sits directly upstream of dispatch and supplies up to three new destination PRs (Tnew) per cycle. Retire pushes Told registers back into it. On a precise-state squash it restores every in-flight allocation in one cycle.

---
 rtl/free_list_if.sv | 31 +++
 rtl/free_list.sv | 85 ++++++++
 tb/tb_free_list.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Purpose: dispatch/retire/squash bundle between rename logic and the PR free list.
// Latency: plain wires; timing is set by the modules on either side.
// Backpressure: dispatch sees per-way grants on free_pr_valid; retire pushes cannot be refused.
// Ports: master drives allocation requests, retire pushes and squash; slave drives
// offered PRs, per-way grants and the debug views of the storage and pointers.
interface free_list_if #(
  parameter int PR = 6
);
  logic [2:0]                  dis_new_pr_en;
  logic [2:0]                  free_pr_valid;
  logic [2:0][PR-1:0]          free_pr;
  logic [2:0]                  retire_en;
  logic [2:0][PR-1:0]          retire_pr;
  logic                        squash;
  logic [2**PR-1:0][PR-1:0]    fl_array_display;
  logic [PR-1:0]               fl_head_display;
  logic [PR-1:0]               fl_tail_display;
  logic                        fl_empty_display;

  modport master (
    output dis_new_pr_en, retire_en, retire_pr, squash,
    input  free_pr_valid, free_pr, fl_array_display, fl_head_display,
           fl_tail_display, fl_empty_display
  );

  modport slave (
    input  dis_new_pr_en, retire_en, retire_pr, squash,
    output free_pr_valid, free_pr, fl_array_display, fl_head_display,
           fl_tail_display, fl_empty_display
  );
endinterface

// File: rtl/free_list.sv
// Purpose: circular free list of physical registers; 3 allocations and 3 retire pushes per cycle.
// Latency: offers are combinational from registered state; pops/pushes visible the next cycle.
// Backpressure: free_pr_valid drops for ways beyond the free count; pushes are never refused.
// Ports: clock/reset (async, active-low) plus the slave side of free_list_if:
// dis_new_pr_en/free_pr/free_pr_valid for allocation, retire_en/retire_pr for frees,
// squash for recovery, and the fl_*_display debug views.
module free_list #(
  parameter int PR   = 6,
  parameter int ARCH = 32
) (
  input  logic         clock,
  input  logic         reset,
  free_list_if.slave   fl
);
  localparam int N    = 2**PR;
  localparam int FREE = N - ARCH;
  localparam int CW   = PR + 1;

  logic [N-1:0][PR-1:0] array_q;
  logic [PR-1:0]        head_q;
  logic [PR-1:0]        tail_q;
  logic [CW-1:0]        count_q;

  logic [2:0][1:0]      k;         // requests from older ways ahead of way i
  logic [2:0]           valid;
  logic [2:0]           grant;
  logic [1:0]           npop;
  logic [2:0]           push_v;
  logic [2:0][1:0]      push_off;  // slot offset from tail for each pushing way
  logic [1:0]           npush;

  always_comb begin
    k[2] = 2'd0;
    k[1] = {1'b0, fl.dis_new_pr_en[2]};
    k[0] = {1'b0, fl.dis_new_pr_en[2]} + {1'b0, fl.dis_new_pr_en[1]};
    for (int i = 0; i < 3; i++) begin
      fl.free_pr[i] = array_q[head_q + PR'(k[i])];
      valid[i]      = count_q > CW'(k[i]);
    end
    fl.free_pr_valid = valid;
    grant = fl.dis_new_pr_en & valid;
    npop  = {1'b0, grant[2]} + {1'b0, grant[1]} + {1'b0, grant[0]};

    // A retire of PR 0 carries no Told and must not consume a slot.
    for (int i = 0; i < 3; i++) begin
      push_v[i] = fl.retire_en[i] && (fl.retire_pr[i] != '0);
    end
    push_off[2] = 2'd0;
    push_off[1] = {1'b0, push_v[2]};
    push_off[0] = {1'b0, push_v[2]} + {1'b0, push_v[1]};
    npush       = push_off[0] + {1'b0, push_v[0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        array_q[j] <= (j < FREE) ? PR'(j + ARCH) : '0;
      end
      head_q  <= '0;
      tail_q  <= PR'(FREE);
      count_q <= CW'(FREE);
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (push_v[i]) begin
          array_q[tail_q + PR'(push_off[i])] <= fl.retire_pr[i];
        end
      end
      tail_q <= tail_q + PR'(npush);
      if (fl.squash) begin
        // Free + in-flight always total FREE, and the in-flight span just behind
        // head is never overwritten, so rewinding head restores every allocation.
        head_q  <= tail_q + PR'(npush) - PR'(FREE);
        count_q <= CW'(FREE);
      end else begin
        head_q  <= head_q + PR'(npop);
        count_q <= count_q + CW'(npush) - CW'(npop);
      end
    end
  end

  assign fl.fl_array_display = array_q;
  assign fl.fl_head_display  = head_q;
  assign fl.fl_tail_display  = tail_q;
  assign fl.fl_empty_display = (count_q == '0);
endmodule

// File: tb/tb_free_list.sv
// Purpose: directed bench for free_list with a queue-free arithmetic reference model.
// Latency: model advances on posedge; outputs compared on every negedge out of reset.
// Backpressure: stimulus never overfills the list; the model flags any overflow.
module tb_free_list;
  localparam int PR   = 6;
  localparam int N    = 64;
  localparam int ARCH = 32;
  localparam int FREE = 32;
  localparam int W    = N * PR;

  logic clock = 1'b0;
  logic reset = 1'b0;

  free_list_if #(.PR(PR)) fl_if ();

  free_list #(.PR(PR), .ARCH(ARCH)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: plain integers, pointers kept modulo N.
  int m_mem [N];
  int m_head;
  int m_tail;
  int m_cnt;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_init();
    for (int j = 0; j < N; j++) m_mem[j] = (j < FREE) ? j + ARCH : 0;
    m_head = 0;
    m_tail = FREE % N;
    m_cnt  = FREE;
  endfunction

  // Walk ways oldest-first; each requesting way consumes the next free entry.
  function automatic void m_alloc(input logic [2:0] en, output logic [2:0] v,
                                  output logic [2:0][PR-1:0] p);
    int idx;
    idx = 0;
    for (int w = 2; w >= 0; w--) begin
      v[w] = (m_cnt > idx);
      p[w] = PR'(m_mem[(m_head + idx) % N]);
      if (en[w]) idx++;
    end
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_init();
    end else begin
      logic [2:0]          v;
      logic [2:0][PR-1:0]  p;
      int                  npop;
      int                  npush;
      m_alloc(fl_if.dis_new_pr_en, v, p);
      npop = 0;
      for (int w = 0; w < 3; w++) if (fl_if.dis_new_pr_en[w] && v[w]) npop++;
      npush = 0;
      for (int w = 2; w >= 0; w--) begin
        if (fl_if.retire_en[w] && fl_if.retire_pr[w] != 0) begin
          m_mem[(m_tail + npush) % N] = int'(fl_if.retire_pr[w]);
          npush++;
        end
      end
      chk("no_overflow", W'(m_cnt + npush <= FREE), W'(1));
      m_tail = (m_tail + npush) % N;
      if (fl_if.squash) begin
        m_head = (m_tail - FREE + N) % N;
        m_cnt  = FREE;
      end else begin
        m_head = (m_head + npop) % N;
        m_cnt  = m_cnt + npush - npop;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      logic [2:0]           v;
      logic [2:0][PR-1:0]   p;
      logic [N-1:0][PR-1:0] arr;
      m_alloc(fl_if.dis_new_pr_en, v, p);
      for (int j = 0; j < N; j++) arr[j] = PR'(m_mem[j]);
      chk("m_valid", W'(fl_if.free_pr_valid), W'(v));
      chk("m_free_pr", W'(fl_if.free_pr), W'(p));
      chk("m_head", W'(fl_if.fl_head_display), W'(m_head));
      chk("m_tail", W'(fl_if.fl_tail_display), W'(m_tail));
      chk("m_empty", W'(fl_if.fl_empty_display), W'(m_cnt == 0));
      chk("m_array", W'(fl_if.fl_array_display), W'(arr));
    end
  end

  task automatic cyc(input logic [2:0] en, input logic [2:0] ren,
                     input logic [PR-1:0] r2, input logic [PR-1:0] r1,
                     input logic [PR-1:0] r0, input logic sq);
    @(posedge clock);
    #1;
    fl_if.dis_new_pr_en = en;
    fl_if.retire_en     = ren;
    fl_if.retire_pr[2]  = r2;
    fl_if.retire_pr[1]  = r1;
    fl_if.retire_pr[0]  = r0;
    fl_if.squash        = sq;
    @(negedge clock);
  endtask

  task automatic async_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_head", W'(fl_if.fl_head_display), W'(0));
    chk("rst_tail", W'(fl_if.fl_tail_display), W'(32));
    chk("rst_empty", W'(fl_if.fl_empty_display), W'(0));
    chk("rst_slot0", W'(fl_if.fl_array_display[0]), W'(32));
    chk("rst_slot31", W'(fl_if.fl_array_display[31]), W'(63));
    chk("rst_slot32", W'(fl_if.fl_array_display[32]), W'(0));
    fl_if.dis_new_pr_en = '0;
    fl_if.retire_en     = '0;
    fl_if.retire_pr     = '0;
    fl_if.squash        = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    m_init();
    fl_if.dis_new_pr_en = '0;
    fl_if.retire_en     = '0;
    fl_if.retire_pr     = '0;
    fl_if.squash        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    // Three allocations straight out of reset.
    cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    chk("t1_valid", W'(fl_if.free_pr_valid), W'(3'b111));
    chk("t1_pr2", W'(fl_if.free_pr[2]), W'(32));
    chk("t1_pr1", W'(fl_if.free_pr[1]), W'(33));
    chk("t1_pr0", W'(fl_if.free_pr[0]), W'(34));
    cyc(3'b000, 3'b000, 0, 0, 0, 1'b0);
    chk("t1_head", W'(fl_if.fl_head_display), W'(3));
    chk("t1_tail", W'(fl_if.fl_tail_display), W'(32));

    // Sparse request: way 1 idle, way 0 takes the next entry.
    async_reset();
    cyc(3'b101, 3'b000, 0, 0, 0, 1'b0);
    chk("t2_pr2", W'(fl_if.free_pr[2]), W'(32));
    chk("t2_pr0", W'(fl_if.free_pr[0]), W'(33));
    cyc(3'b000, 3'b000, 0, 0, 0, 1'b0);
    chk("t2_head", W'(fl_if.fl_head_display), W'(2));

    // Drain to empty.
    async_reset();
    repeat (10) cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    chk("t3_valid", W'(fl_if.free_pr_valid), W'(3'b110));
    chk("t3_pr2", W'(fl_if.free_pr[2]), W'(62));
    chk("t3_pr1", W'(fl_if.free_pr[1]), W'(63));
    cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    chk("t3_empty", W'(fl_if.fl_empty_display), W'(1));
    chk("t3_valid_empty", W'(fl_if.free_pr_valid), W'(3'b000));

    // Retire into an empty list; PR 0 is dropped, no same-cycle bypass.
    cyc(3'b000, 3'b111, 5, 0, 9, 1'b0);
    chk("t4_valid_same", W'(fl_if.free_pr_valid), W'(3'b000));
    cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    chk("t4_valid", W'(fl_if.free_pr_valid), W'(3'b110));
    chk("t4_pr2", W'(fl_if.free_pr[2]), W'(5));
    chk("t4_pr1", W'(fl_if.free_pr[1]), W'(9));
    chk("t4_tail", W'(fl_if.fl_tail_display), W'(34));

    // Steady push+pop until tail wraps past 63.
    for (int n = 0; n < 12; n++) begin
      cyc(3'b111, 3'b111, PR'(1 + 3 * n), PR'(2 + 3 * n), PR'(3 + 3 * n), 1'b0);
      if (n == 10) chk("t5_slot63", W'(fl_if.free_pr[0]), W'(30));
      if (n == 11) chk("t5_slot0", W'(fl_if.free_pr[2]), W'(31));
    end
    cyc(3'b000, 3'b000, 0, 0, 0, 1'b0);
    chk("t5_tail_wrap", W'(fl_if.fl_tail_display), W'(6));

    // Squash with a concurrent retire.
    async_reset();
    cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    cyc(3'b111, 3'b000, 0, 0, 0, 1'b0);
    cyc(3'b111, 3'b100, 7, 0, 0, 1'b1);
    cyc(3'b000, 3'b000, 0, 0, 0, 1'b0);
    chk("t6_head", W'(fl_if.fl_head_display), W'(1));
    chk("t6_tail", W'(fl_if.fl_tail_display), W'(33));
    chk("t6_pr2", W'(fl_if.free_pr[2]), W'(33));
    chk("t6_slot32", W'(fl_if.fl_array_display[32]), W'(7));
    chk("t6_valid", W'(fl_if.free_pr_valid), W'(3'b111));

    // Mid-run async reset, then a little traffic from clean state.
    cyc(3'b011, 3'b000, 0, 0, 0, 1'b0);
    async_reset();
    cyc(3'b110, 3'b000, 0, 0, 0, 1'b0);
    chk("t7_pr2", W'(fl_if.free_pr[2]), W'(32));
    repeat (2) cyc(3'b000, 3'b000, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
